spike_pkt_assembler: RTL
========================

// Module: spike_pkt_assembler
// PURPOSE
//   Read-side consumer of async_fifo, in the rclk domain. Pops DSIZE-bit bytes (rinc/rempty/rdata)
//   and packs NBYTES consecutive bytes, little-endian, into one packet word. Emits packets on a
//   valid/ready stream to the SNN core input stage. Sustains 1 byte/cycle when unthrottled.
// PARAMETERS
//   DSIZE        8   FIFO data width; must match async_fifo DSIZE
//   NBYTES       4   bytes per packet (>=2)
//   TIMEOUT_CYC  16  idle cycles before a partial packet is flushed (only with SPKT_TIMEOUT_EN)
// PORTS
//   rclk     in   1             clock; same clock as async_fifo rclk
//   rrst     in   1             reset, synchronous, active-high
//   rempty   in   1             async_fifo empty flag
//   rdata    in   DSIZE         async_fifo head data; valid whenever rempty=0 (show-ahead)
//   rinc     out  1             pop request to async_fifo
//   m_valid  out  1             packet valid
//   m_ready  in   1             downstream accepts when m_valid & m_ready at posedge rclk
//   m_data   out  NBYTES*DSIZE  packet; byte k at [k*DSIZE +: DSIZE]; first popped byte is k=0
//   m_nbytes out  $clog2(NBYTES+1)  number of valid bytes in m_data
// BEHAVIOUR
//   - Reset, synchronous on rrst=1: m_valid=0, m_data=0, m_nbytes=0, cnt=0, state=FILL, idle=0.
//     rinc=0 while rrst=1. A partial packet is discarded. A packet held in the output register
//     is also dropped.
//   - Output slot free: slot_free = !m_valid | m_ready.
//   - FSM:
//     FILL: rinc = !rempty (combinational). On pop, rdata goes into acc byte cnt and cnt++.
//       If the pop completes a packet (cnt==NBYTES-1) and slot_free:
//         m_data <= completed word on the same edge; m_valid=1; m_nbytes=NBYTES; cnt=0; stay FILL.
//       If the pop completes a packet and the slot is not free: go to HOLD.
//     HOLD: rinc=0. When slot_free: load the output register from acc; cnt=0; go to FILL.
//   - Latency: last byte popped at edge N -> m_valid=1 after edge N (zero added bubbles).
//   - Output register: m_valid clears on accept unless a new packet loads on the same edge.
//     m_data and m_nbytes hold stable while m_valid & !m_ready.
//   - rempty=1 mid-packet: no pop. Partial bytes are retained and cnt is unchanged.
//   - Bytes of acc not yet written read as 0.
//   - rinc is never asserted when rempty=1 (no underflow). Counter arithmetic is unsigned;
//     cnt wraps only via the explicit clear to 0.
// CONFIGURATION
//   SPKT_TIMEOUT_EN defined:
//     - idle counter: +1 per FILL cycle with cnt>0 and no pop; cleared on pop or on flush.
//       Saturates at TIMEOUT_CYC.
//     - When idle==TIMEOUT_CYC and slot_free: flush. m_data = acc with unfilled bytes 0,
//       m_nbytes=cnt, m_valid=1, cnt=0.
//     - If the slot is not free, the flush waits.
//     - If a pop and the flush condition occur in the same cycle, the pop wins; no flush.
//   SPKT_TIMEOUT_EN undefined:
//     - No idle counter. A partial packet waits indefinitely. m_nbytes is always NBYTES
//       when m_valid=1.
// STRUCTURE
//   - spike_pkt_defs.vh (shared include): state encodings SPKT_ST_FILL=1'b0, SPKT_ST_HOLD=1'b1;
//     byte-lane index macro. Used by the SNN core input stage.
//   - Sub-module spike_pkt_timer: idle counter with clear, enable, saturate and expire flag.
//     Instantiated only under SPKT_TIMEOUT_EN.
//   - Everything else is inline: FSM, acc/cnt, output register.
// TESTING (bench drives async_fifo DSIZE=8 ASIZE=4 + this block, NBYTES=4)
//   1. Write bytes 1..16, m_ready=1
//      -> four packets 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D, each m_nbytes=4.
//         rinc high on 16 consecutive cycles once FIFO non-empty and unthrottled.
//   2. Same stimulus, m_ready=0 until 20 cycles after the last write
//      -> HOLD after 8 pops; rinc=0; m_data=0x04030201 held stable.
//         After release: all 4 packets arrive in order, none lost.
//   3. Write 1,2 (pause 5 cycles), then 3,4
//      -> single packet 0x04030201; no output during the gap (timeout off, or gap < TIMEOUT_CYC).
//   4. SPKT_TIMEOUT_EN: write 0xAA,0xBB, then nothing
//      -> TIMEOUT_CYC idle cycles later, m_data=0x0000BBAA, m_nbytes=2.
//         Then write 1..4 -> 0x04030201, m_nbytes=4.
//   5. Assert rrst for 1 cycle after 2 bytes popped (FIFO keeps 1..16 remainder)
//      -> m_valid=0, m_data=0. Next packet is built from the next FIFO bytes starting at byte 0.
//   6. Accept and completion on the same edge (m_valid=1, m_ready=1, 4th byte popped)
//      -> m_valid stays 1 with the new word. No bubble, no duplicate.

Source files
------------

// File: rtl/spike_pkt_pkg.sv
// Shared definitions for the spike packet assembler and the SNN core input stage.
package spike_pkt_pkg;

   typedef enum logic [0:0] {
      StFill = 1'b0,
      StHold = 1'b1
   } spkt_state_e;

   // Low bit index of byte lane k in a packet word.
   function automatic int unsigned lane_lo(input int unsigned k, input int unsigned dsize);
      return k * dsize;
   endfunction

endpackage

// File: rtl/spike_pkt_timer.sv
// Idle cycle counter with clear, enable and saturation; flags expiry when the count hits LIMIT.
module spike_pkt_timer #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int unsigned W = $clog2(LIMIT + 1);

   logic [W-1:0] idle_q, idle_d;

   always_comb begin
      idle_d = idle_q;
      if (clr_i) begin
         idle_d = '0;
      end else if (en_i && (idle_q != W'(LIMIT))) begin
         idle_d = idle_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end

   assign expired_o = (idle_q == W'(LIMIT));

endmodule

// File: rtl/spike_pkt_assembler.sv
// Packs NBYTES show-ahead FIFO bytes little-endian into one valid/ready packet word.
// Build option SPKT_TIMEOUT_EN: flush a partial packet after TIMEOUT_CYC idle cycles.
module spike_pkt_assembler
   import spike_pkt_pkg::*;
#(
   parameter int unsigned DSIZE       = 8,
   parameter int unsigned NBYTES      = 4,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic                        rclk,
   input  logic                        rrst,
   input  logic                        rempty,
   input  logic [DSIZE-1:0]            rdata,
   output logic                        rinc,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [NBYTES*DSIZE-1:0]     m_data,
   output logic [$clog2(NBYTES+1)-1:0] m_nbytes
);
   localparam int unsigned CW = $clog2(NBYTES + 1);
   localparam int unsigned AW = NBYTES * DSIZE;

   spkt_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] acc_q, acc_d, acc_next;
   logic          m_valid_q, m_valid_d;
   logic [AW-1:0] m_data_q, m_data_d;
   logic [CW-1:0] m_nbytes_q, m_nbytes_d;
   logic          slot_free;
   logic          timeout_hit;

   assign slot_free = !m_valid_q || m_ready;

`ifdef SPKT_TIMEOUT_EN
   logic timer_expired;

   spike_pkt_timer #(
      .LIMIT(TIMEOUT_CYC)
   ) u_timer (
      .clk_i    (rclk),
      .rst_i    (rrst),
      .clr_i    (rinc || (timeout_hit && slot_free)),
      .en_i     ((state_q == StFill) && (cnt_q != '0) && !rinc),
      .expired_o(timer_expired)
   );

   assign timeout_hit = timer_expired && (cnt_q != '0);
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      acc_next   = acc_q;
      m_valid_d  = m_valid_q && !m_ready;
      m_data_d   = m_data_q;
      m_nbytes_d = m_nbytes_q;
      rinc       = 1'b0;

      case (state_q)
         StFill: begin
            rinc = !rempty && !rrst;
            for (int unsigned k = 0; k < NBYTES; k++) begin
               if (CW'(k) == cnt_q) begin
                  acc_next[lane_lo(k, DSIZE) +: DSIZE] = rdata;
               end
            end
            if (rinc) begin
               if (cnt_q == CW'(NBYTES - 1)) begin
                  if (slot_free) begin
                     // Completed word bypasses acc so the packet appears with no bubble.
                     m_valid_d  = 1'b1;
                     m_data_d   = acc_next;
                     m_nbytes_d = CW'(NBYTES);
                     cnt_d      = '0;
                     acc_d      = '0;
                  end else begin
                     acc_d   = acc_next;
                     state_d = StHold;
                  end
               end else begin
                  acc_d = acc_next;
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (timeout_hit && slot_free) begin
               m_valid_d  = 1'b1;
               m_data_d   = acc_q;
               m_nbytes_d = cnt_q;
               cnt_d      = '0;
               acc_d      = '0;
            end
         end
         StHold: begin
            if (slot_free) begin
               m_valid_d  = 1'b1;
               m_data_d   = acc_q;
               m_nbytes_d = CW'(NBYTES);
               cnt_d      = '0;
               acc_d      = '0;
               state_d    = StFill;
            end
         end
      endcase
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         state_q    <= StFill;
         cnt_q      <= '0;
         acc_q      <= '0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_nbytes_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         m_nbytes_q <= m_nbytes_d;
      end
   end

   assign m_valid  = m_valid_q;
   assign m_data   = m_data_q;
   assign m_nbytes = m_nbytes_q;

endmodule
